// File: rtl/mono_mode_ctrl.sv
//============================================================================
// mono_mode_ctrl : display-mode selector with vsync-aligned commit; the
// hotkey/lock/holdoff path is built only when MONO_HOTKEY_EN is defined.
// Revision 1.0
//============================================================================
`default_nettype none

module mono_mode_ctrl #(
  parameter bit         VSYNC_ACTIVE_LOW = 1'b1,
  parameter int         SYNC_STAGES      = 2,
  parameter logic [1:0] RESET_MODE       = 2'b00,
  parameter int         HOLDOFF_FRAMES   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_we,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  input  logic       key_cycle,
  input  logic       vga_vsync,
  output logic [1:0] mode,
  output logic       pend_valid
);

  localparam logic VS_IDLE = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
  // Out-of-range stage counts are clamped to the legal 2..4 window.
  localparam int   NSYNC   = (SYNC_STAGES < 2) ? 2 :
                             (SYNC_STAGES > 4) ? 4 : SYNC_STAGES;

  logic [NSYNC-1:0] vs_sync;
  logic             vs_last;
  logic             fb_det;
  logic             fb;

  logic [1:0]       pend_mode;
  logic             lock;
  logic             holdoff_busy;
  logic             key_accept;
  logic [1:0]       key_target;
  logic             commit;

  // Synchroniser, edge detect, and a registered fb pulse (glitch-free commit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync <= {NSYNC{VS_IDLE}};
      vs_last <= VS_IDLE;
      fb      <= 1'b0;
    end else begin
      vs_sync <= {vs_sync[NSYNC-2:0], vga_vsync};
      vs_last <= vs_sync[NSYNC-1];
      fb      <= fb_det;
    end
  end

  assign fb_det = (vs_sync[NSYNC-1] != VS_IDLE) && (vs_last == VS_IDLE);
  assign commit = fb && pend_valid;

`ifdef MONO_HOTKEY_EN
  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_FRAMES);

  logic [3:0] hold_cnt;
  logic       pend_from_key;
  logic       unused_din;

  assign key_target   = (pend_valid ? pend_mode : mode) + 2'd1;
  assign key_accept   = key_cycle && !lock && (hold_cnt == 4'd0) && !io_we;
  assign holdoff_busy = (hold_cnt != 4'd0);
  assign unused_din   = ^io_din[6:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock          <= 1'b0;
      pend_from_key <= 1'b0;
      hold_cnt      <= 4'd0;
    end else begin
      if (io_we) begin
        lock <= io_din[7];
      end

      if (io_we) begin
        pend_from_key <= 1'b0;
      end else if (key_accept) begin
        pend_from_key <= 1'b1;
      end else if (commit) begin
        pend_from_key <= 1'b0;
      end

      // Holdoff only ages on boundaries that commit nothing.
      if (fb) begin
        if (pend_valid) begin
          if (pend_from_key) begin
            hold_cnt <= HOLD_LOAD;
          end
        end else if (hold_cnt != 4'd0) begin
          hold_cnt <= hold_cnt - 4'd1;
        end
      end
    end
  end
`else
  logic unused_inputs;

  assign key_target    = 2'b00;
  assign key_accept    = 1'b0;
  assign lock          = 1'b0;
  assign holdoff_busy  = 1'b0;
  assign unused_inputs = ^{key_cycle, io_din[7:2]};
`endif

  // A request in the fb cycle overwrites the pending slot after the commit
  // has consumed the pre-edge value, so pend_valid stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode       <= RESET_MODE;
      pend_mode  <= 2'b00;
      pend_valid <= 1'b0;
    end else begin
      if (commit) begin
        mode <= pend_mode;
      end

      if (io_we) begin
        pend_mode  <= io_din[1:0];
        pend_valid <= 1'b1;
      end else if (key_accept) begin
        pend_mode  <= key_target;
        pend_valid <= 1'b1;
      end else if (fb) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign io_dout = {lock, 1'b0, holdoff_busy, pend_valid, pend_mode, mode};

endmodule

`default_nettype wire
